// File: rtl/sn_wrt_resp.sv
// Purpose : SN-side write responder; tracks AW/W per transaction and returns one B per completed burst.
// Latency : AW accepted at N is W-matchable at N+1; last W beat at M gives BVALID at M+1 (FIFO empty).
// Backpr. : AW stalls when full or on an open-ID collision; W stalls without a CAM hit; B holds until BREADY.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   AWVALID/AWREADY/AWID/AWLEN/AW_SrcID   write request with return-route source
//   WVALID/WREADY/WID/WLAST          write data beats, matched to open entries by WID
//   BVALID/BREADY/BID/BRESP/B_SrcID  write response, routed back via B_SrcID
//   outstanding                      registered count of valid entries

module sn_wrt_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         empty_o,
    output logic [W-1:0] head_dat_o
);
    // Small index FIFO, one slot per tracker entry, so it is never pushed when full.
    // Head is a combinational read of the slot at the read pointer.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_vld_i) begin
                mem_q[wr_q[AW-1:0]] <= push_dat_i;
                wr_q                <= wr_q + ONE;
            end
            if (pop_i) begin
                rd_q <= rd_q + ONE;
            end
        end
    end

    assign empty_o    = (wr_q == rd_q);
    assign head_dat_o = mem_q[rd_q[AW-1:0]];
endmodule

module sn_wrt_resp #(
    parameter int SN_TRACKER_NUM = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    input  logic [10:0]                       AWID,
    input  logic [7:0]                        AWLEN,
    input  logic [1:0]                        AW_SrcID,
    input  logic                              WVALID,
    output logic                              WREADY,
    input  logic [10:0]                       WID,
    input  logic                              WLAST,
    output logic                              BVALID,
    input  logic                              BREADY,
    output logic [10:0]                       BID,
    output logic [1:0]                        BRESP,
    output logic [1:0]                        B_SrcID,
    output logic [$clog2(SN_TRACKER_NUM):0]   outstanding
);
    localparam int IW = $clog2(SN_TRACKER_NUM);
    localparam int CW = IW + 1;

    logic [SN_TRACKER_NUM-1:0] valid_q;
    logic [SN_TRACKER_NUM-1:0] done_q;
    logic [SN_TRACKER_NUM-1:0] err_q;
    logic [10:0]               id_q  [SN_TRACKER_NUM];
    logic [1:0]                src_q [SN_TRACKER_NUM];
    logic [8:0]                rem_q [SN_TRACKER_NUM];
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             cnt_d;

    logic          any_free;
    logic          id_collide;
    logic          w_hit;
    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] head_idx;
    logic          fifo_empty;
    logic          alloc_fire;
    logic          w_fire;
    logic          b_fire;
    logic          w_last_beat;

    always_comb begin
        any_free   = 1'b0;
        alloc_idx  = '0;
        id_collide = 1'b0;
        w_hit      = 1'b0;
        w_idx      = '0;
        // Scan downwards so the last assignment leaves the lowest free index.
        for (int i = SN_TRACKER_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free  = 1'b1;
                alloc_idx = IW'(i);
            end
        end
        // Only open (valid, not yet done) entries take part in ID matching.
        // The AW collision stall keeps at most one open entry per ID, so the
        // W CAM is one-hot.
        for (int i = 0; i < SN_TRACKER_NUM; i++) begin
            if (valid_q[i] && !done_q[i]) begin
                if (id_q[i] == AWID) begin
                    id_collide = 1'b1;
                end
                if (id_q[i] == WID) begin
                    w_hit = 1'b1;
                    w_idx = IW'(i);
                end
            end
        end
    end

    assign AWREADY     = ~rst & any_free & ~id_collide;
    assign WREADY      = ~rst & w_hit;
    assign BVALID      = ~rst & ~fifo_empty;
    assign alloc_fire  = AWVALID & AWREADY;
    assign w_fire      = WVALID & WREADY;
    assign b_fire      = BVALID & BREADY;
    assign w_last_beat = (rem_q[w_idx] == 9'd1);

    assign BID         = rst ? 11'd0 : id_q[head_idx];
    assign B_SrcID     = rst ? 2'd0  : src_q[head_idx];
    assign BRESP       = (rst || !err_q[head_idx]) ? 2'b00 : 2'b10;
    assign outstanding = rst ? '0 : cnt_q;

    // Alloc and pop can coincide; the freed slot is only visible next cycle.
    assign cnt_d = cnt_q + CW'(alloc_fire) - CW'(b_fire);

    sn_wrt_resp_fifo #(
        .DEPTH (SN_TRACKER_NUM),
        .W     (IW)
    ) u_cmpl_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (w_fire & w_last_beat),
        .push_dat_i (w_idx),
        .pop_i      (b_fire),
        .empty_o    (fifo_empty),
        .head_dat_o (head_idx)
    );

    // alloc_idx is free, w_idx is open and head_idx is done, so the three
    // updates below never target the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < SN_TRACKER_NUM; i++) begin
                id_q[i]  <= '0;
                src_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (alloc_fire) begin
                valid_q[alloc_idx] <= 1'b1;
                done_q[alloc_idx]  <= 1'b0;
                err_q[alloc_idx]   <= 1'b0;
                id_q[alloc_idx]    <= AWID;
                src_q[alloc_idx]   <= AW_SrcID;
                rem_q[alloc_idx]   <= {1'b0, AWLEN} + 9'd1;
            end
            if (w_fire) begin
                rem_q[w_idx] <= rem_q[w_idx] - 9'd1;
                // A WLAST that disagrees with the beat counter flags the burst,
                // but the counter alone decides when the burst ends.
                err_q[w_idx] <= err_q[w_idx] | (WLAST ^ w_last_beat);
                if (w_last_beat) begin
                    done_q[w_idx] <= 1'b1;
                end
            end
            if (b_fire) begin
                valid_q[head_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sn_wrt_resp.md
# sn_wrt_resp

SN-side write responder: the target end of the write path whose AW/W traffic is routed by the RN write tracker. Accepts AW requests carrying a return-route source ID, tracks W beats per transaction by WID, and issues one B response per completed burst, routed back via B_SrcID. Sits between the NoC ingress port of a slave node and its B egress port.

## Interface
- SN_TRACKER_NUM, 16, max outstanding write transactions (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- AWVALID  in  1  AW request valid
- AWREADY  out  1  AW accept
- AWID  in  11  write transaction ID
- AWLEN  in  8  beats minus one
- AW_SrcID  in  2  requesting RN, used as B return route
- WVALID  in  1  W beat valid
- WREADY  out  1  W beat accept
- WID  in  11  ID of the W beat
- WLAST  in  1  last-beat marker from initiator
- BVALID  out  1  B response valid
- BREADY  in  1  B accept
- BID  out  11  ID of completed transaction
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- B_SrcID  out  2  return-route target for B
- outstanding  out  $clog2(SN_TRACKER_NUM)+1  count of valid entries

## Operation
- Entry state: valid, done, err, id[10:0], src[1:0], remaining[8:0].
- AWREADY = ~rst & (any free entry) & ~(any valid & ~done entry with id == AWID). ID-collision stall keeps the WID CAM one-hot.
- On AWVALID & AWREADY: lowest-index free entry gets valid=1, done=0, err=0, id=AWID, src=AW_SrcID, remaining=AWLEN+1 (9-bit, no overflow; AWLEN=255 gives 256).
- WID CAM matches registered entries with valid & ~done only. WREADY = ~rst & CAM hit. An entry allocated this cycle is not matchable until next cycle.
- On WVALID & WREADY: hit entry's remaining decrements by 1. err sets if WLAST=1 with remaining≠1 or WLAST=0 with remaining==1. Completion is counter-based; WLAST never terminates a burst early.
- Beat with remaining==1: done=1, entry index pushed to completion FIFO (depth SN_TRACKER_NUM, one slot per entry, cannot overflow).
- BVALID = FIFO non-empty. BID, B_SrcID, BRESP (err ? 2'b10 : 2'b00) come from the head entry; held stable while BVALID & ~BREADY.
- On BVALID & BREADY: pop FIFO, clear entry valid. B order equals completion order, not AW order.
- outstanding = popcount(valid), registered.
- WVALID with no CAM hit: WREADY=0, beat stalls indefinitely (no drop, no error).

## Timing
- Reset: all entries invalid, FIFO empty; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, B_SrcID=0, outstanding=0 while rst=1. AWREADY=1 in first cycle after rst deasserts.
- AW accepted cycle N → entry valid and WID-matchable at N+1; outstanding updates at N+1.
- Final W beat accepted cycle M → BVALID=1 at M+1 if FIFO was empty; otherwise after earlier entries drain.
- B handshake cycle K → entry free at K+1; a full tracker raises AWREADY at K+1, never at K.
- Same-cycle AW alloc and B pop: both happen; freed slot not reused that cycle, outstanding net unchanged.
- Same-cycle FIFO push and pop: count unchanged; if FIFO was one-deep, new head drives B at next cycle.
- Same-cycle AW and W with equal IDs, new transaction: W stalls one cycle.
- AWLEN=0: single beat, BVALID at M+1.
- rst asserted mid-burst: all state discarded next edge, no B issued for in-flight transactions.

## Test plan
- AWID=0x005, AWLEN=3, AW_SrcID=2; four W beats WID=0x005, WLAST on 4th → one B: BID=0x005, B_SrcID=2, BRESP=00, BVALID exactly one cycle after 4th beat, outstanding 1→0 after handshake.
- Fill 16 entries with distinct IDs, AWLEN=0 → AWREADY=0 on 17th AW; complete and pop one B at cycle K → AWREADY=1 at K+1, new entry takes freed lowest index.
- AW IDs 0x001 (AWLEN=7) then 0x002 (AWLEN=0); complete 0x002 first → B order 0x002 then 0x001.
- AWLEN=1, WLAST=1 on first beat → second beat still accepted, BRESP=10; AWID equal to an open entry's ID → AWREADY=0 until that entry's last beat accepted.
- BREADY=0 for 5 cycles with BVALID=1 → BID/BRESP/B_SrcID stable; simultaneous AW alloc and B pop → outstanding unchanged.
- rst pulse mid-burst (2 of 4 beats sent) → BVALID never asserts, outstanding=0, AWREADY=1 after rst deasserts.
